// File: rtl/sort_ctrl.sv
// In-place ascending bubble-sort sequencer for a single-port, synchronous-read memory.
// Outputs are registered from the next-state decode, so they follow the current state with no extra delay.
module sort_ctrl #(
  parameter int ADDRWIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [ADDRWIDTH-1:0] n,
  input  logic                 a_gt_b,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 wr_sel,
  output logic                 ld_a,
  output logic                 ld_b,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RDA, S_RDB, S_LDB, S_CMP, S_WRA, S_WRB, S_NEXT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] i_q, i_d;
  logic [ADDRWIDTH-1:0] limit_q, limit_d;
  logic [ADDRWIDTH-1:0] n_q, n_d;
  logic                 swapped_q, swapped_d;
  logic [ADDRWIDTH-1:0] i_q_p1, i_d_p1;

  logic [ADDRWIDTH-1:0] addr_d;
  logic                 mem_rd_d, mem_wr_d, wr_sel_d, ld_a_d, ld_b_d, busy_d, done_d;

  assign i_q_p1 = i_q + ADDRWIDTH'(1);
  assign i_d_p1 = i_d + ADDRWIDTH'(1);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    limit_d   = limit_q;
    n_d       = n_q;
    swapped_d = swapped_q;
    case (state_q)
      S_IDLE: if (go) begin
        if (n >= ADDRWIDTH'(2)) begin
          n_d     = n;
          state_d = S_INIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_INIT: begin
        i_d       = '0;
        limit_d   = n_q - ADDRWIDTH'(1);
        swapped_d = 1'b0;
        state_d   = S_RDA;
      end
      S_RDA: state_d = S_RDB;
      S_RDB: state_d = S_LDB;
      S_LDB: state_d = S_CMP;
      S_CMP: state_d = a_gt_b ? S_WRA : S_NEXT;  // equal keys stay put
      S_WRA: state_d = S_WRB;
      S_WRB: begin
        swapped_d = 1'b1;
        state_d   = S_NEXT;
      end
      S_NEXT: begin
        if (i_q_p1 < limit_q) begin
          i_d     = i_q_p1;
          state_d = S_RDA;
        end else if (!swapped_q || limit_q == ADDRWIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          limit_d   = limit_q - ADDRWIDTH'(1);
          i_d       = '0;
          swapped_d = 1'b0;
          state_d   = S_RDA;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode of the state being entered, registered below
  always_comb begin
    addr_d   = '0;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    wr_sel_d = 1'b0;
    ld_a_d   = 1'b0;
    ld_b_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_INIT: busy_d = 1'b1;
      S_RDA: begin
        busy_d = 1'b1; addr_d = i_d; mem_rd_d = 1'b1;
      end
      S_RDB: begin
        busy_d = 1'b1; addr_d = i_d_p1; mem_rd_d = 1'b1; ld_a_d = 1'b1;
      end
      S_LDB: begin
        busy_d = 1'b1; ld_b_d = 1'b1;
      end
      S_CMP: busy_d = 1'b1;
      S_WRA: begin
        busy_d = 1'b1; addr_d = i_d; mem_wr_d = 1'b1; wr_sel_d = 1'b1;
      end
      S_WRB: begin
        busy_d = 1'b1; addr_d = i_d_p1; mem_wr_d = 1'b1;
      end
      S_NEXT: busy_d = 1'b1;
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      limit_q   <= '0;
      n_q       <= '0;
      swapped_q <= 1'b0;
      addr      <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      wr_sel    <= 1'b0;
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      limit_q   <= limit_d;
      n_q       <= n_d;
      swapped_q <= swapped_d;
      addr      <= addr_d;
      mem_rd    <= mem_rd_d;
      mem_wr    <= mem_wr_d;
      wr_sel    <= wr_sel_d;
      ld_a      <= ld_a_d;
      ld_b      <= ld_b_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl: models memory, A/B registers and comparator around the controller.
// Memory words carry {tag, key}; only the low 8-bit key is compared, so tags expose stability.
module tb_sort_ctrl;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst, go, a_gt_b;
  logic [AW-1:0] n_in, addr;
  logic          mem_rd, mem_wr, wr_sel, ld_a, ld_b, busy, done;

  always #5 clk = ~clk;

  sort_ctrl #(.ADDRWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n_in), .a_gt_b(a_gt_b),
    .addr(addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .wr_sel(wr_sel),
    .ld_a(ld_a), .ld_b(ld_b), .busy(busy), .done(done)
  );

  logic [15:0] mem [512];
  logic [15:0] init_mem [512];
  logic [15:0] rdata, reg_a, reg_b;
  logic        load_pulse;
  logic [AW-1:0] n_cur;
  int wr_cnt, rd_cnt, done_cnt, busy_cnt, ldb_cnt, oob_cnt;
  logic [AW:0] wlog [4096];

  int pass_cnt, total_cnt;

  assign a_gt_b = reg_a[7:0] > reg_b[7:0];

  initial begin
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0; ldb_cnt = 0; oob_cnt = 0;
    rdata = '0; reg_a = '0; reg_b = '0;
  end

  always @(posedge clk) begin
    if (load_pulse) begin
      for (int k = 0; k < 512; k++) mem[k] <= init_mem[k];
    end else if (mem_wr === 1'b1) begin
      mem[addr] <= wr_sel ? reg_b : reg_a;
    end
    if (mem_rd === 1'b1) rdata <= mem[addr];
    if (ld_a === 1'b1) reg_a <= rdata;
    if (ld_b === 1'b1) reg_b <= rdata;
    if (mem_wr === 1'b1) begin
      if (wr_cnt < 4096) wlog[wr_cnt] <= {addr, wr_sel};
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd === 1'b1) rd_cnt <= rd_cnt + 1;
    if ((mem_rd === 1'b1 || mem_wr === 1'b1) && addr >= n_cur) oob_cnt <= oob_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (ld_b === 1'b1) ldb_cnt <= ldb_cnt + 1;
  end

  task automatic load_mem();
    @(negedge clk);
    load_pulse = 1'b1;
    @(posedge clk); #1;
    load_pulse = 1'b0;
  endtask

  // Cycle numbering: accepting edge closes cycle 0; first negedge afterwards is cycle 1.
  task automatic run_sort(input logic [AW-1:0] nn, input bit disturb, output int done_cyc);
    @(negedge clk);
    n_in = nn; n_cur = nn; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      if (disturb) begin
        go = c[0];
        n_in = 9'd2;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    go = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b1; n_in = 9'd5; n_cur = 9'd511; load_pulse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({addr, mem_rd, mem_wr, wr_sel, ld_a, ld_b, busy, done} !== 16'h0)
        $display("FAIL reset_outputs cycle %0d: got %h expected 0000", k,
                 {addr, mem_rd, mem_wr, wr_sel, ld_a, ld_b, busy, done});
      else pass_cnt++;
    end
    rst = 1'b0; go = 1'b0;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if ({addr, mem_rd, mem_wr, wr_sel, ld_a, ld_b, busy, done} !== 16'h0)
      $display("FAIL reset_idle_after: got %h expected 0000",
               {addr, mem_rd, mem_wr, wr_sel, ld_a, ld_b, busy, done});
    else pass_cnt++;
  endtask

  task automatic test_sorted_n4();
    int dc, w0, d0, c0;
    for (int k = 0; k < 4; k++) init_mem[k] = 16'(k + 1);
    load_mem();
    w0 = wr_cnt; d0 = done_cnt; c0 = ldb_cnt;
    run_sort(9'd4, 1'b0, dc);
    total_cnt++;
    if (dc !== 17) $display("FAIL n4_done_cycle: got %0d expected 17", dc); else pass_cnt++;
    total_cnt++;
    if (wr_cnt - w0 !== 0) $display("FAIL n4_writes: got %0d expected 0", wr_cnt - w0); else pass_cnt++;
    total_cnt++;
    if (ldb_cnt - c0 !== 3) $display("FAIL n4_compares: got %0d expected 3", ldb_cnt - c0); else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL n4_done_pulses: got %0d expected 1", done_cnt - d0); else pass_cnt++;
    total_cnt++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== {16'd1, 16'd2, 16'd3, 16'd4})
      $display("FAIL n4_memory: got %h %h %h %h expected 1 2 3 4", mem[0], mem[1], mem[2], mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_reverse_n3();
    int dc, w0, d0, bad;
    logic [AW:0] exp_log [6];
    exp_log = '{{9'd0, 1'b1}, {9'd1, 1'b0}, {9'd1, 1'b1}, {9'd2, 1'b0}, {9'd0, 1'b1}, {9'd1, 1'b0}};
    init_mem[0] = 16'd3; init_mem[1] = 16'd2; init_mem[2] = 16'd1;
    load_mem();
    w0 = wr_cnt; d0 = done_cnt;
    run_sort(9'd3, 1'b0, dc);
    total_cnt++;
    if (dc !== 23) $display("FAIL n3_done_cycle: got %0d expected 23", dc); else pass_cnt++;
    total_cnt++;
    if (wr_cnt - w0 !== 6) $display("FAIL n3_writes: got %0d expected 6", wr_cnt - w0); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 6; k++) if (wlog[w0 + k] !== exp_log[k]) bad++;
    total_cnt++;
    if (bad !== 0) $display("FAIL n3_write_sequence: got %0d wrong entries expected 0", bad); else pass_cnt++;
    total_cnt++;
    if ({mem[0], mem[1], mem[2]} !== {16'd1, 16'd2, 16'd3})
      $display("FAIL n3_memory: got %h %h %h expected 1 2 3", mem[0], mem[1], mem[2]);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL n3_done_pulses: got %0d expected 1", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_degenerate();
    int dc, b0, r0, w0;
    for (int nn = 0; nn < 2; nn++) begin
      b0 = busy_cnt; r0 = rd_cnt; w0 = wr_cnt;
      run_sort(AW'(nn), 1'b0, dc);
      total_cnt++;
      if (dc !== 1) $display("FAIL degen_n%0d_done_cycle: got %0d expected 1", nn, dc); else pass_cnt++;
      total_cnt++;
      if ({busy_cnt - b0, rd_cnt - r0, wr_cnt - w0} !== {32'd0, 32'd0, 32'd0})
        $display("FAIL degen_n%0d_activity: got busy %0d rd %0d wr %0d expected 0 0 0",
                 nn, busy_cnt - b0, rd_cnt - r0, wr_cnt - w0);
      else pass_cnt++;
    end
  endtask

  task automatic test_go_ignored();
    int dc_plain, dc_dist, w0, d0;
    for (int k = 0; k < 4; k++) init_mem[k] = 16'(4 - k);
    load_mem();
    run_sort(9'd4, 1'b0, dc_plain);
    total_cnt++;
    if (dc_plain !== 44) $display("FAIL plain_n4_done_cycle: got %0d expected 44", dc_plain); else pass_cnt++;
    load_mem();
    w0 = wr_cnt; d0 = done_cnt;
    run_sort(9'd4, 1'b1, dc_dist);
    total_cnt++;
    if (dc_dist !== 44) $display("FAIL disturbed_done_cycle: got %0d expected 44", dc_dist); else pass_cnt++;
    total_cnt++;
    if (wr_cnt - w0 !== 12 || done_cnt - d0 !== 1)
      $display("FAIL disturbed_activity: got wr %0d done %0d expected 12 1", wr_cnt - w0, done_cnt - d0);
    else pass_cnt++;
    total_cnt++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== {16'd1, 16'd2, 16'd3, 16'd4})
      $display("FAIL disturbed_memory: got %h %h %h %h expected 1 2 3 4", mem[0], mem[1], mem[2], mem[3]);
    else pass_cnt++;
  endtask

  // Sorts whatever mem[0..32] holds and checks against a stable insertion sort of the snapshot.
  task automatic sort33_and_check(input string name);
    logic [15:0] exp [33];
    logic [15:0] t;
    int dc, d0, o0, bad, j;
    for (int k = 0; k < 33; k++) exp[k] = mem[k];
    for (int k = 1; k < 33; k++) begin
      t = exp[k];
      j = k - 1;
      while (j >= 0 && exp[j][7:0] > t[7:0]) begin
        exp[j + 1] = exp[j];
        j--;
      end
      exp[j + 1] = t;
    end
    d0 = done_cnt; o0 = oob_cnt;
    run_sort(9'd33, 1'b0, dc);
    bad = 0;
    for (int k = 0; k < 33; k++) if (mem[k] !== exp[k]) bad++;
    total_cnt++;
    if (bad !== 0) $display("FAIL %s_order: got %0d misplaced words expected 0", name, bad); else pass_cnt++;
    total_cnt++;
    if (dc < 0 || done_cnt - d0 !== 1)
      $display("FAIL %s_done: got cycle %0d pulses %0d expected one pulse", name, dc, done_cnt - d0);
    else pass_cnt++;
    total_cnt++;
    if (oob_cnt - o0 !== 0) $display("FAIL %s_addr_range: got %0d out-of-range accesses expected 0", name, oob_cnt - o0);
    else pass_cnt++;
  endtask

  task automatic test_random33();
    for (int k = 0; k < 33; k++) init_mem[k] = {8'(k), 8'($urandom_range(0, 15))};
    load_mem();
    sort33_and_check("rand33");
  endtask

  task automatic test_reset_in_wra();
    bit found;
    int w0, b0;
    for (int k = 0; k < 33; k++) init_mem[k] = {8'(k), 8'(200 - 3 * k)};
    load_mem();
    @(negedge clk);
    n_in = 9'd33; n_cur = 9'd33; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_wr === 1'b1 && wr_sel === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!found) $display("FAIL rst_wra_reached: got 0 expected 1"); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    w0 = wr_cnt; b0 = busy_cnt;
    total_cnt++;
    if ({addr, mem_rd, mem_wr, wr_sel, ld_a, ld_b, busy, done} !== 16'h0)
      $display("FAIL rst_wra_outputs: got %h expected 0000",
               {addr, mem_rd, mem_wr, wr_sel, ld_a, ld_b, busy, done});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (wr_cnt !== w0 || busy_cnt !== b0)
      $display("FAIL rst_wra_quiet: got wr %0d busy %0d expected wr %0d busy %0d", wr_cnt, busy_cnt, w0, b0);
    else pass_cnt++;
    sort33_and_check("after_rst");
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    load_pulse = 1'b0;
    test_reset();
    test_sorted_n4();
    test_reverse_n3();
    test_degenerate();
    test_go_ignored();
    test_random33();
    test_reset_in_wra();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
